// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory sequencer: shares the single memory port between the boot loader and fetch.
// Optional delivered-instruction counter is enabled by defining FETCH_CNT_EN.
module imem_fetch_ctrl #(
    parameter int unsigned DEPTH    = 1024,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     halt_req,
    input  logic                     ld_we,
    input  logic [31:0]              ld_addr,
    input  logic [31:0]              ld_wdata,
    output logic                     ld_ready,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     if_valid,
    input  logic                     if_ready,
    output logic [31:0]              if_pc,
    output logic [31:0]              if_instr,
    output logic                     misalign_err,
    output logic [31:0]              fetch_count,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    output logic                     mem_we,
    output logic [31:0]              mem_wdata,
    input  logic [31:0]              mem_rdata
);

    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        misalign_q, misalign_d;
    logic        ld_ready_q, ld_ready_d;
    logic        ld_addr_unused_s;

    // Only the word-index bits of the loader address reach the memory.
    assign ld_addr_unused_s = ^{ld_addr[31:IW+2], ld_addr[1:0]};

    // Next-state logic: loader states wait for start; RUN fetches with halt > redirect > advance > hold.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        misalign_d = misalign_q;
        case (state_q)
            ST_BOOT, ST_HALT: begin
                if_valid_d = 1'b0;
                if (start) begin
                    pc_d    = RESET_PC;
                    state_d = ST_RUN;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    if_valid_d = 1'b0;
                    state_d    = ST_HALT;
                end else if (redirect_valid) begin
                    if_valid_d = 1'b0;
                    // A misaligned target stops the core without moving the PC.
                    if (redirect_pc[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                        state_d    = ST_HALT;
                    end else begin
                        pc_d = redirect_pc;
                    end
                end else if (!if_valid_q || if_ready) begin
                    if_instr_d = mem_rdata;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    pc_d       = pc_q + 32'd4;
                end else begin
                    if_valid_d = 1'b1;
                end
            end
            default: begin
                state_d    = ST_BOOT;
                if_valid_d = 1'b0;
            end
        endcase
        ld_ready_d = (state_d != ST_RUN);
    end

    // Memory port mux: loader owns the port outside RUN, the PC owns it in RUN.
    always_comb begin
        if (state_q == ST_RUN) begin
            mem_addr  = pc_q[IW+1:2];
            mem_we    = 1'b0;
            mem_wdata = 32'h0000_0000;
        end else begin
            mem_addr  = ld_addr[IW+1:2];
            mem_we    = ld_we;
            mem_wdata = ld_wdata;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_pc_q    <= 32'h0000_0000;
            if_instr_q <= 32'h0000_0000;
            misalign_q <= 1'b0;
            ld_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            misalign_q <= misalign_d;
            ld_ready_q <= ld_ready_d;
        end
    end

    assign ld_ready     = ld_ready_q;
    assign if_valid     = if_valid_q;
    assign if_pc        = if_pc_q;
    assign if_instr     = if_instr_q;
    assign misalign_err = misalign_q;

`ifdef FETCH_CNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;

    // Count every completed decode handshake.
    always_comb begin
        if (if_valid_q && if_ready) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end else begin
            fetch_count_d = fetch_count_q;
        end
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_q <= 32'h0000_0000;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`else
    assign fetch_count = 32'h0000_0000;
`endif

endmodule
